// File: rtl/div_datapath_if.sv
// Operand/control bundle between the divider control unit and the datapath,
// plus the registered result bundle returned to the consumer.
interface div_datapath_if;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        W_ctrl;
  logic        SLL_ctrl;
  logic        subu_ctrl;
  logic        SRL_ctrl;
  logic        Ready;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivZero;
  logic        Valid;

  modport master (
    output Dividend, Divisor, W_ctrl, SLL_ctrl, subu_ctrl, SRL_ctrl, Ready,
    input  Quotient, Remainder, DivZero, Valid
  );

  modport slave (
    input  Dividend, Divisor, W_ctrl, SLL_ctrl, subu_ctrl, SRL_ctrl, Ready,
    output Quotient, Remainder, DivZero, Valid
  );
endinterface

// File: rtl/div_datapath.sv
// Restoring-division datapath: 65-bit remainder/quotient shift register,
// divisor register and result capture on the rising edge of Ready.
module div_datapath (
  input logic           clk,
  input logic           Reset,
  div_datapath_if.slave bus
);

  logic [64:0] rem_q, rem_d;
  logic [31:0] div_q, div_d;
  logic [31:0] divd_copy_q, divd_copy_d;
  logic        ready_dly_q;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rmd_q, rmd_d;
  logic        divzero_q, divzero_d;
  logic        valid_q, valid_d;

  // Partial remainder is 33 bits wide so divisors >= 2^31 keep their MSB;
  // only the low 32 bits of a successful difference survive the shift.
  logic        borrow;
  logic [31:0] diff_lo;
  logic        capture;

  assign borrow  = rem_q[64:32] < {1'b0, div_q};
  assign diff_lo = rem_q[63:32] - div_q;
  assign capture = bus.Ready && !ready_dly_q;

  // Next state of the operand registers: load, final right shift, or one step
  always_comb begin
    rem_d       = rem_q;
    div_d       = div_q;
    divd_copy_d = divd_copy_q;
    if (bus.W_ctrl) begin
      rem_d       = {33'b0, bus.Dividend};
      div_d       = bus.Divisor;
      divd_copy_d = bus.Dividend;
    end else if (bus.SRL_ctrl) begin
      rem_d = {1'b0, rem_q[64:33], rem_q[31:0]};
    end else if (bus.SLL_ctrl) begin
      if (bus.subu_ctrl && !borrow) begin
        rem_d = {diff_lo, rem_q[31:0], 1'b1};
      end else begin
        rem_d = {rem_q[63:0], 1'b0};
      end
    end
  end

  // Result capture on the first cycle Ready is seen high; Valid is a pulse
  always_comb begin
    quot_d    = quot_q;
    rmd_d     = rmd_q;
    divzero_d = divzero_q;
    valid_d   = 1'b0;
    if (capture) begin
      valid_d = 1'b1;
      if (div_q != 32'd0) begin
        quot_d    = rem_q[31:0];
        rmd_d     = rem_q[63:32];
        divzero_d = 1'b0;
      end else begin
        quot_d    = 32'hFFFF_FFFF;
        rmd_d     = divd_copy_q;
        divzero_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rem_q       <= '0;
      div_q       <= '0;
      divd_copy_q <= '0;
      ready_dly_q <= 1'b0;
      quot_q      <= '0;
      rmd_q       <= '0;
      divzero_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      rem_q       <= rem_d;
      div_q       <= div_d;
      divd_copy_q <= divd_copy_d;
      ready_dly_q <= bus.Ready;
      quot_q      <= quot_d;
      rmd_q       <= rmd_d;
      divzero_q   <= divzero_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.Quotient  = quot_q;
  assign bus.Remainder = rmd_q;
  assign bus.DivZero   = divzero_q;
  assign bus.Valid     = valid_q;

endmodule
